// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared widths, FSM state encoding and the request struct
// used by the two-host register-bus arbiter.
package bus_arbiter_pkg;

  localparam int BUS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 rw;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: host request/response ports and the chain head/tail bus.
// slave = arbiter side, master = hosts plus chain (testbench side).
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  // host 0
  logic [BUS_WIDTH-1:0] h0_addr_i;
  logic [BUS_WIDTH-1:0] h0_wdata_i;
  logic                 h0_rw_i;
  logic                 h0_valid_i;
  logic                 h0_ready_o;
  logic [BUS_WIDTH-1:0] h0_rdata_o;
  logic                 h0_rvalid_o;
  logic                 h0_err_o;
  // host 1
  logic [BUS_WIDTH-1:0] h1_addr_i;
  logic [BUS_WIDTH-1:0] h1_wdata_i;
  logic                 h1_rw_i;
  logic                 h1_valid_i;
  logic                 h1_ready_o;
  logic [BUS_WIDTH-1:0] h1_rdata_o;
  logic                 h1_rvalid_o;
  logic                 h1_err_o;
  // chain head
  logic [BUS_WIDTH-1:0] addr_o;
  logic [BUS_WIDTH-1:0] wdata_o;
  logic [BUS_WIDTH-1:0] rdata_o;
  logic                 rw_o;
  logic                 valid_o;
  // chain tail
  logic [BUS_WIDTH-1:0] addr_i;
  logic [BUS_WIDTH-1:0] wdata_i;
  logic [BUS_WIDTH-1:0] rdata_i;
  logic                 rw_i;
  logic                 valid_i;

  modport slave (
    input  h0_addr_i, h0_wdata_i, h0_rw_i, h0_valid_i,
    output h0_ready_o, h0_rdata_o, h0_rvalid_o, h0_err_o,
    input  h1_addr_i, h1_wdata_i, h1_rw_i, h1_valid_i,
    output h1_ready_o, h1_rdata_o, h1_rvalid_o, h1_err_o,
    output addr_o, wdata_o, rdata_o, rw_o, valid_o,
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i
  );

  modport master (
    output h0_addr_i, h0_wdata_i, h0_rw_i, h0_valid_i,
    input  h0_ready_o, h0_rdata_o, h0_rvalid_o, h0_err_o,
    output h1_addr_i, h1_wdata_i, h1_rw_i, h1_valid_i,
    input  h1_ready_o, h1_rdata_o, h1_rvalid_o, h1_err_o,
    input  addr_o, wdata_o, rdata_o, rw_o, valid_o,
    output addr_i, wdata_i, rdata_i, rw_i, valid_i
  );

endinterface

// File: rtl/bus_arbiter_rr_grant2.sv
// rr_grant2: combinational two-requester round-robin pick.
// i_last names the host granted most recently; on a tie the other one wins.
module rr_grant2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // one-hot grant; a lone requester always wins
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-host round-robin arbiter for the daisy-chained register bus.
// One transaction is in flight at a time: issue at the chain head, wait for it
// at the chain tail, return data to the issuing host.
// Optional chain-response timeout: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus
);

  state_t               r_state;
  logic                 r_last;      // host granted most recently
  logic                 r_owner;     // host owning the in-flight transaction
  bus_req_t             r_head;      // latched request, held on the chain head
  logic                 r_valid_o;
  logic [BUS_WIDTH-1:0] r_h0_rdata;
  logic [BUS_WIDTH-1:0] r_h1_rdata;
  logic                 r_h0_rvalid;
  logic                 r_h1_rvalid;

  logic [1:0]           w_req;
  logic [1:0]           w_gnt;
  logic                 w_accept;
  logic                 w_win;
  logic                 w_expire;
  logic                 w_done;
  logic                 w_rsp_err;
  logic [BUS_WIDTH-1:0] w_rsp_data;
  bus_req_t             w_h0_req;
  bus_req_t             w_h1_req;
  logic                 w_unused;

  assign w_h0_req = '{addr: bus.h0_addr_i, wdata: bus.h0_wdata_i, rw: bus.h0_rw_i};
  assign w_h1_req = '{addr: bus.h1_addr_i, wdata: bus.h1_wdata_i, rw: bus.h1_rw_i};
  assign w_req    = {bus.h1_valid_i, bus.h0_valid_i};

  rr_grant2 u_grant (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_accept = (r_state == IDLE) && (w_gnt != 2'b00);
  assign w_win    = w_gnt[1];

  // ready is combinational so the host sees acceptance in the request cycle
  assign bus.h0_ready_o = rst_n & (r_state == IDLE) & w_gnt[0];
  assign bus.h1_ready_o = rst_n & (r_state == IDLE) & w_gnt[1];

  // a tail return wins over a coincident timeout expiry
  assign w_done     = (r_state == WAIT) && (bus.valid_i || w_expire);
  assign w_rsp_err  = !bus.valid_i && w_expire;
  assign w_rsp_data = bus.valid_i ? bus.rdata_i : '0;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_h0_err;
  logic             r_h1_err;

  // expiry on the WAIT cycle that would bring the count to TIMEOUT
  assign w_expire = (r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

  // WAIT-cycle counter, cleared while entering WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == ISSUE) r_cnt <= '0;
    else if (r_state == WAIT)  r_cnt <= r_cnt + CNT_W'(1);
  end

  // error flag for the owner, valid alongside the response strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h0_err <= 1'b0;
      r_h1_err <= 1'b0;
    end else if (w_done) begin
      r_h0_err <= !r_owner & w_rsp_err;
      r_h1_err <=  r_owner & w_rsp_err;
    end else if (r_state == RESPOND) begin
      r_h0_err <= 1'b0;
      r_h1_err <= 1'b0;
    end
  end

  assign bus.h0_err_o = r_h0_err;
  assign bus.h1_err_o = r_h1_err;
  assign w_unused     = ^{bus.addr_i, bus.wdata_i, bus.rw_i};
`else
  assign w_expire     = 1'b0;
  assign bus.h0_err_o = 1'b0;
  assign bus.h1_err_o = 1'b0;
  assign w_unused     = ^{bus.addr_i, bus.wdata_i, bus.rw_i, w_rsp_err, TIMEOUT[0]};
`endif

  // transaction FSM with registered chain-head and host-response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_head      <= '0;
      r_valid_o   <= 1'b0;
      r_h0_rdata  <= '0;
      r_h1_rdata  <= '0;
      r_h0_rvalid <= 1'b0;
      r_h1_rvalid <= 1'b0;
    end else begin
      r_h0_rvalid <= 1'b0;
      r_h1_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_head    <= w_win ? w_h1_req : w_h0_req;
            r_valid_o <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_valid_o <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            if (r_owner) begin
              r_h1_rvalid <= 1'b1;
              r_h1_rdata  <= w_rsp_data;
            end else begin
              r_h0_rvalid <= 1'b1;
              r_h0_rdata  <= w_rsp_data;
            end
            r_state <= RESPOND;
          end
        end
        RESPOND: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.addr_o      = r_head.addr;
  assign bus.wdata_o     = r_head.wdata;
  assign bus.rw_o        = r_head.rw;
  assign bus.valid_o     = r_valid_o;
  assign bus.rdata_o     = '0;
  assign bus.h0_rdata_o  = r_h0_rdata;
  assign bus.h1_rdata_o  = r_h1_rdata;
  assign bus.h0_rvalid_o = r_h0_rvalid;
  assign bus.h1_rvalid_o = r_h1_rvalid;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter. A round-robin grant model
// pushes expected issues/responses at acceptance; the monitor pops and
// compares them when the chain head and host response strobes fire.
// Timeout scenario runs only when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct { int host; logic [15:0] rdata; logic err; int tacc; } rsp_t;
  typedef struct { bus_req_t req; int tacc; } iss_t;

  rsp_t rsp_q[$];
  iss_t iss_q[$];
  int   gnt_obs[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_vi = -100;
  int   chain_dly = 4;
  bit   chain_mute = 1'b0;
  int   stray_req = 0;
  int   stray_ack = 0;

  // model state, owned by the monitor
  bit          m_busy;
  logic        m_last;
  logic [15:0] m_rdata[2];
  bus_req_t    m_head;
  logic [1:0]  mon_req, mon_exp, mon_rv;
  int          mon_pick;
  bus_req_t    mon_r;
  iss_t        mon_is;
  rsp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] chain_data(input logic [15:0] a);
    return (a == 16'h0003) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic bus_req_t host_fields(input int n);
    bus_req_t r;
    if (n == 0) r = '{addr: bif.h0_addr_i, wdata: bif.h0_wdata_i, rw: bif.h0_rw_i};
    else        r = '{addr: bif.h1_addr_i, wdata: bif.h1_wdata_i, rw: bif.h1_rw_i};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // present a request from host n (call just after a posedge) and hold it until accepted
  task automatic host_req(input int n, input logic [15:0] a, input logic [15:0] d, input logic rw);
    bit ok = 1'b0;
    if (n == 0) begin
      bif.h0_addr_i = a; bif.h0_wdata_i = d; bif.h0_rw_i = rw; bif.h0_valid_i = 1'b1;
    end else begin
      bif.h1_addr_i = a; bif.h1_wdata_i = d; bif.h1_rw_i = rw; bif.h1_valid_i = 1'b1;
    end
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if ((n == 0 && bif.h0_ready_o) || (n == 1 && bif.h1_ready_o)) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (n == 0) bif.h0_valid_i = 1'b0;
    else        bif.h1_valid_i = 1'b0;
    chk("accept_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && (m_busy || rsp_q.size() != 0); k++) @(negedge clk);
    chk("drain", 32'(rsp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_head"}, {bif.addr_o, bif.wdata_o}, 32'd0);
    chk({tag, "_rdata"}, {bif.h0_rdata_o, bif.h1_rdata_o}, 32'd0);
    chk({tag, "_ctl"}, 32'({bif.valid_o, bif.rw_o, bif.h0_rvalid_o, bif.h1_rvalid_o,
                            bif.h0_err_o, bif.h1_err_o, bif.h0_ready_o, bif.h1_ready_o}), 32'd0);
    chk({tag, "_rdata_o"}, 32'(bif.rdata_o), 32'd0);
  endtask

  // chain model: returns each head request after chain_dly cycles, or a stray on demand
  initial begin
    logic [15:0] a;
    bif.valid_i = 1'b0; bif.rdata_i = '0; bif.addr_i = '0; bif.wdata_i = '0; bif.rw_i = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack++;
        bif.valid_i = 1'b1; bif.rdata_i = 16'hDEAD;
        @(negedge clk);
        bif.valid_i = 1'b0;
      end else if (rst_n && bif.valid_o && !chain_mute) begin
        a = bif.addr_o;
        repeat (chain_dly) @(negedge clk);
        bif.valid_i = 1'b1; bif.rdata_i = chain_data(a); bif.addr_i = a;
        t_vi = cyc;
        @(negedge clk);
        bif.valid_i = 1'b0;
      end
    end
  end

  // monitor: grant model, issue check, response scoreboard, hold checks
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rsp_q.delete(); iss_q.delete();
      m_busy = 1'b0; m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0; m_head = '0;
    end else begin
      if (bif.h0_ready_o) gnt_obs.push_back(0);
      if (bif.h1_ready_o) gnt_obs.push_back(1);
      mon_req = {bif.h1_valid_i, bif.h0_valid_i};
      mon_exp = 2'b00;
      if (!m_busy && mon_req != 2'b00) begin
        mon_pick = (mon_req == 2'b11) ? (m_last ? 0 : 1) : (mon_req[0] ? 0 : 1);
        mon_exp  = (mon_pick == 0) ? 2'b01 : 2'b10;
        m_last   = mon_pick[0];
        m_busy   = 1'b1;
        mon_r    = host_fields(mon_pick);
        iss_q.push_back('{req: mon_r, tacc: cyc});
        rsp_q.push_back('{host: mon_pick,
                          rdata: (TO_EN && chain_mute) ? 16'h0000 : chain_data(mon_r.addr),
                          err: TO_EN && chain_mute, tacc: cyc});
      end
      chk("ready", 32'({bif.h1_ready_o, bif.h0_ready_o}), 32'(mon_exp));

      if (bif.valid_o) begin
        if (iss_q.size() == 0) chk("valid_o_extra", 32'(bif.valid_o), 32'd0);
        else begin
          mon_is = iss_q.pop_front();
          chk("head_addr", 32'(bif.addr_o), 32'(mon_is.req.addr));
          chk("head_wdata", 32'(bif.wdata_o), 32'(mon_is.req.wdata));
          chk("head_rw", 32'(bif.rw_o), 32'(mon_is.req.rw));
          chk("head_rdata", 32'(bif.rdata_o), 32'd0);
          chk("issue_lat", 32'(cyc), 32'(mon_is.tacc + 1));
          m_head = mon_is.req;
        end
      end else begin
        chk("head_hold", {bif.addr_o, bif.wdata_o}, {m_head.addr, m_head.wdata});
      end

      mon_rv = {bif.h1_rvalid_o, bif.h0_rvalid_o};
      if (mon_rv != 2'b00) begin
        if (rsp_q.size() == 0) chk("rvalid_stray", 32'(mon_rv), 32'd0);
        else begin
          mon_e = rsp_q.pop_front();
          chk("rsp_host", 32'(mon_rv), (mon_e.host == 0) ? 32'd1 : 32'd2);
          chk("rsp_rdata", 32'((mon_e.host == 0) ? bif.h0_rdata_o : bif.h1_rdata_o), 32'(mon_e.rdata));
          chk("rsp_err", 32'((mon_e.host == 0) ? bif.h0_err_o : bif.h1_err_o), 32'(mon_e.err));
          if (mon_e.err) chk("rsp_lat_to", 32'(cyc), 32'(mon_e.tacc + 2 + TO));
          else           chk("rsp_lat", 32'(cyc), 32'(t_vi + 1));
          m_rdata[mon_e.host] = mon_e.rdata;
          m_busy = 1'b0;
        end
      end
      chk("h0_rdata_hold", 32'(bif.h0_rdata_o), 32'(m_rdata[0]));
      chk("h1_rdata_hold", 32'(bif.h1_rdata_o), 32'(m_rdata[1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still going at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bif.h0_addr_i = '0; bif.h0_wdata_i = '0; bif.h0_rw_i = 1'b0; bif.h0_valid_i = 1'b0;
    bif.h1_addr_i = '0; bif.h1_wdata_i = '0; bif.h1_rw_i = 1'b0; bif.h1_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // host 0 read, chain delay 4
    chain_dly = 4;
    host_req(0, 16'h0003, 16'h0000, 1'b0);
    wait_idle();

    // host 1 write
    chain_dly = 2;
    host_req(1, 16'h0010, 16'h1234, 1'b1);
    wait_idle();

    // both hosts continuously valid: alternate starting with host 0
    chain_dly = 3;
    base = gnt_obs.size();
    fork
      for (int i = 0; i < 3; i++) host_req(0, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b0);
      for (int j = 0; j < 3; j++) host_req(1, 16'h0200 + 16'(j), 16'h2000 + 16'(j), 1'b0);
    join
    wait_idle();
    chk("rr_count", 32'(gnt_obs.size() - base), 32'd6);
    for (int i = 0; i < 6 && base + i < gnt_obs.size(); i++)
      chk("rr_order", 32'(gnt_obs[base + i]), 32'(i % 2));

    // stray tail return while idle: dropped, no strobes, FSM still usable
    stray_req++;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    chain_dly = 1;
    host_req(1, 16'h0020, 16'h0000, 1'b0);
    wait_idle();

`ifdef BUS_ARBITER_TIMEOUT_EN
    // chain never answers: error response after TO wait cycles, then recovery
    chain_mute = 1'b1;
    host_req(0, 16'h0040, 16'h0000, 1'b0);
    wait_idle();
    chain_mute = 1'b0;
    chain_dly = 5;
    host_req(0, 16'h0041, 16'h0000, 1'b0);
    wait_idle();
`endif

    // reset in WAIT, then a late tail return: no response, host 0 wins next tie
    chain_dly = 10;
    host_req(0, 16'h0050, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk_all_zero("post_rst");
    @(posedge clk); #1;
    chain_dly = 2;
    base = gnt_obs.size();
    fork
      host_req(0, 16'h0060, 16'h0000, 1'b0);
      host_req(1, 16'h0061, 16'h0000, 1'b0);
    join
    wait_idle();
    chk("post_rst_grant", (gnt_obs.size() > base) ? 32'(gnt_obs[base]) : 32'hFFFF_FFFF, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-host arbiter for the 16-bit register bus that daisy-chains through the logic analyzer's register file, trigger block and sample memory. It accepts requests from two independent hosts, for example the UART and Ethernet front ends. It issues one transaction at a time into the head of the core chain and waits for the transaction to emerge at the chain tail. It then returns the read data and completion to the host that issued it, granting hosts round-robin.

## Interface
Parameters:
- TIMEOUT, 1024: cycles to wait for the chain-tail response before aborting. Only used when the timeout feature is compiled in.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- hN_addr_i  in  16  host N request address (N = 0, 1, same set per host).
- hN_wdata_i  in  16  host N write data.
- hN_rw_i  in  1  host N direction: 1 = write, 0 = read.
- hN_valid_i  in  1  host N request pending. The host holds it and all request fields stable until accepted.
- hN_ready_o  out  1  host N request accepted this cycle.
- hN_rdata_o  out  16  host N response data.
- hN_rvalid_o  out  1  host N one-cycle response strobe, for reads and writes alike.
- hN_err_o  out  1  qualifies hN_rvalid_o: the transaction timed out.
- addr_o, wdata_o, rdata_o  out  16 each  request into the chain head.
- rw_o, valid_o  out  1 each  request into the chain head.
- addr_i, wdata_i, rdata_i  in  16 each  chain-tail return.
- rw_i, valid_i  in  1 each  chain-tail return.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any hN_valid_i is high, select a winner.
  - If both are high, the winner is the host not granted last.
  - Assert the winner's hN_ready_o combinationally in this cycle.
  - Latch the winner's fields and the grant owner, update the last-grant pointer, then go to ISSUE.
- ISSUE: drive the latched fields on the chain head, assert valid_o and rdata_o = 0, then go to WAIT.
- WAIT:
  - On valid_i, capture rdata_i and go to RESPOND.
  - addr_i, wdata_i and rw_i are ignored.
- RESPOND: pulse owner's hN_rvalid_o with hN_rdata_o = captured data, then return to IDLE.
- valid_i in IDLE, ISSUE or RESPOND is a stray and is dropped without side effects.
- Only one transaction is outstanding at a time. The non-owner's hN_ready_o stays low throughout.

## Timing
- Accept at cycle T, valid_o at T+1 (one cycle only).
- If valid_i arrives at cycle W, hN_rvalid_o is high at W+1.
- The earliest next acceptance is W+2.
- Chain-head outputs are registered. The chain head's addr_o, wdata_o and rw_o hold their last values, and valid_o stays low, outside ISSUE.
- valid_i in the same cycle as valid_o (zero-latency chain) is not possible: WAIT is entered at T+2, so a response at T+1 is a stray.
- Reset values:
  - every output 0;
  - state IDLE;
  - last-grant pointer = host 1, so host 0 wins the first tie.
- Reset asserted mid-transaction: return to IDLE immediately. No response is issued for the dropped request, and a late valid_i after reset is a stray.
- hN_rdata_o holds its value between strobes. hN_err_o is meaningful only with hN_rvalid_o.

## Configuration
- BUS_ARBITER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT without valid_i, go to RESPOND with rdata 0 and hN_err_o = 1.
  - If valid_i and expiry coincide, valid_i wins and err is 0.
- Undefined: WAIT lasts indefinitely, no counter is synthesised, and hN_err_o is tied 0.

## Structure
- Package bus_arbiter_pkg:
  - BUS_WIDTH = 16;
  - state enum (IDLE, ISSUE, WAIT, RESPOND);
  - a bus request struct {addr, wdata, rw}.
- Sub-module rr_grant2: combinational two-requester round-robin pick from requests plus the last-grant pointer. It outputs a one-hot grant.

## Test plan
- Single host-0 read of addr 0x0003, chain delay 4: ready at T, valid_o at T+1, valid_i at T+5 with rdata 0xBEEF → h0_rvalid_o and h0_rdata_o = 0xBEEF at T+6, h1 outputs stay 0.
- Both hosts valid continuously, 6 transactions → grant order 0, 1, 0, 1, 0, 1, with each response routed to the correct host.
- Host 1 write (addr 0x0010, wdata 0x1234) → chain head shows 0x0010/0x1234/rw = 1 for exactly one cycle, then h1_rvalid_o pulses with err = 0.
- With BUS_ARBITER_TIMEOUT_EN and TIMEOUT = 8, chain never responds → h0_rvalid_o with h0_err_o = 1 and rdata 0 exactly 8 WAIT cycles after entry. Next request then proceeds normally.
- Reset pulsed during WAIT, then valid_i arrives → no hN_rvalid_o, all outputs 0, the next request is granted to host 0.
- Stray valid_i in IDLE → no state change and no response strobes.
